// File: rtl/adc_pack.sv
// ADC sample packer: truncates DDR-demuxed samples to 8/4/2/1 bits, packs them into
// 16*NCH-bit words and buffers them in a FWFT FIFO. Optional macro ADC_PACK_OVF_COUNT_EN.
module adc_pack #(
  parameter int NCH   = 4,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [1:0]                 mode,
  input  logic [16*NCH-1:0]          in_data,
  output logic [16*NCH-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  input  logic                       ovf_clr,
  output logic [15:0]                ovf_count
);

  localparam int W  = 16 * NCH;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic          en_q;
  logic [1:0]    mode_q, mode_prev_q;
  logic [W-1:0]  data_q;

  logic [2:0]    phase_q, phase_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  word_q, word_d;
  logic          word_vld_q, word_vld_d;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;

  logic          wr, pop, drop, full;

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q        <= 1'b0;
      mode_q      <= 2'd0;
      mode_prev_q <= 2'd0;
      data_q      <= '0;
    end else begin
      en_q        <= en;
      mode_q      <= mode;
      mode_prev_q <= mode_q;
      data_q      <= in_data;
    end
  end

  // Each sample keeps its top bits; sample k = 2*channel + (0 earlier, 1 later).
  logic [W-1:0]   chunk8;
  logic [W/2-1:0] chunk4;
  logic [W/4-1:0] chunk2;
  logic [W/8-1:0] chunk1;

  generate
    for (genvar gi = 0; gi < 2 * NCH; gi++) begin : g_smp
      assign chunk8[gi*8 +: 8] = data_q[gi*8 +: 8];
      assign chunk4[gi*4 +: 4] = data_q[gi*8+4 +: 4];
      assign chunk2[gi*2 +: 2] = data_q[gi*8+6 +: 2];
      assign chunk1[gi]        = data_q[gi*8+7];
    end
  endgenerate

  logic [W-1:0] chunk_sel, shifted, merged;
  logic [2:0]   phase_eff, phase_max;
  logic         mode_chg;
  int           off;

  always_comb begin
    chunk_sel = chunk8;
    phase_max = 3'd0;
    case (mode_q)
      2'd0: begin chunk_sel = chunk8;     phase_max = 3'd0; end
      2'd1: begin chunk_sel = W'(chunk4); phase_max = 3'd1; end
      2'd2: begin chunk_sel = W'(chunk2); phase_max = 3'd3; end
      default: begin chunk_sel = W'(chunk1); phase_max = 3'd7; end
    endcase
  end

  assign mode_chg  = (mode_q != mode_prev_q);
  assign phase_eff = mode_chg ? 3'd0 : phase_q;

  always_comb begin
    off        = int'(phase_eff) * (W >> mode_q);
    shifted    = chunk_sel << off;
    merged     = ((phase_eff == 3'd0) ? '0 : acc_q) | shifted;
    phase_d    = phase_q;
    acc_d      = acc_q;
    word_d     = word_q;
    word_vld_d = 1'b0;
    if (!en_q) begin
      phase_d = 3'd0;
      acc_d   = '0;
    end else if (phase_eff == phase_max) begin
      word_d     = merged;
      word_vld_d = 1'b1;
      phase_d    = 3'd0;
      acc_d      = '0;
    end else begin
      acc_d   = merged;
      phase_d = phase_eff + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q    <= 3'd0;
      acc_q      <= '0;
      word_q     <= '0;
      word_vld_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      acc_q      <= acc_d;
      word_q     <= word_d;
      word_vld_q <= word_vld_d;
    end
  end

  // A full FIFO drops the incoming word even when a pop frees a slot on the same edge.
  assign full = (level_q == LW'(DEPTH));
  assign pop  = (level_q != '0) && out_ready;
  assign wr   = word_vld_q && !full;
  assign drop = word_vld_q && full;

  always_comb begin
    level_d = level_q + LW'(wr) - LW'(pop);
    ovf_d   = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr_q] <= word_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr)  wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef ADC_PACK_OVF_COUNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (drop) begin
      if (ovf_clr)                   ovf_cnt_d = 16'd1;
      else if (ovf_cnt_q != 16'hFFFF) ovf_cnt_d = ovf_cnt_q + 16'd1;
    end else if (ovf_clr) begin
      ovf_cnt_d = 16'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ovf_cnt_q <= 16'd0;
    else       ovf_cnt_q <= ovf_cnt_d;
  end

  assign ovf_count = ovf_cnt_q;
`else
  assign ovf_count = 16'h0000;
`endif

  assign out_data  = mem[rd_ptr_q];
  assign out_valid = (level_q != '0);
  assign level     = level_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_adc_pack.sv
// Self-checking bench for adc_pack: directed table, hand-written corner sequences and
// randomized traffic checked every cycle against a bit-accumulating queue model.
module tb_adc_pack;
  localparam int NCH   = 4;
  localparam int DEPTH = 16;
  localparam int W     = 16 * NCH;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset, en, out_ready, ovf_clr;
  logic [1:0]    mode;
  logic [W-1:0]  in_data, out_data;
  logic          out_valid, overflow;
  logic [LW-1:0] level;
  logic [15:0]   ovf_count;

  adc_pack #(.NCH(NCH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .in_data(in_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .overflow(overflow), .ovf_clr(ovf_clr), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: a queue FIFO, a two-edge write delay and a bit accumulator.
  logic [W-1:0] mq[$];
  logic         dl_v[2];
  logic [W-1:0] dl_w[2];
  logic [W-1:0] m_acc;
  int           m_nbits;
  logic [1:0]   m_prev;
  logic         m_ovf;
  int           m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_edge();
    logic       pop, wr, drop, new_v;
    logic [W-1:0] new_w;
    logic [7:0]   byt;
    logic [W-1:0] bits;
    int           b;
    if (reset) begin
      mq.delete();
      dl_v[0] = 0; dl_v[1] = 0;
      m_nbits = 0; m_acc = '0; m_prev = 2'd0;
      m_ovf = 0; m_cnt = 0;
      return;
    end
    pop  = (mq.size() > 0) && out_ready;
    wr   = dl_v[0];
    drop = wr && (mq.size() == DEPTH);
    if (pop) void'(mq.pop_front());
    if (wr && !drop) mq.push_back(dl_w[0]);
    if (drop) begin
      m_ovf = 1;
`ifdef ADC_PACK_OVF_COUNT_EN
      if (ovf_clr) m_cnt = 1;
      else if (m_cnt < 65535) m_cnt++;
`endif
    end else if (ovf_clr) begin
      m_ovf = 0;
      m_cnt = 0;
    end
    new_v = 0;
    new_w = '0;
    if (!en) begin
      m_nbits = 0;
    end else begin
      if (mode != m_prev) m_nbits = 0;
      if (m_nbits == 0) m_acc = '0;
      b = 8 >> mode;
      for (int k = 0; k < 2 * NCH; k++) begin
        byt  = in_data[8*k +: 8];
        bits = W'(byt >> (8 - b));
        m_acc = m_acc | (bits << m_nbits);
        m_nbits += b;
      end
      if (m_nbits == W) begin
        new_v = 1; new_w = m_acc; m_nbits = 0;
      end
    end
    m_prev  = mode;
    dl_v[0] = dl_v[1]; dl_w[0] = dl_w[1];
    dl_v[1] = new_v;   dl_w[1] = new_w;
  endtask

  task automatic check_model();
    chk("valid", out_valid, mq.size() > 0);
    chk("level", level, mq.size());
    chk("overflow", overflow, m_ovf);
    chk("ovf_count", ovf_count, m_cnt);
    if (mq.size() > 0) chk("data", out_data, mq[0]);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  typedef struct {
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] data;
    logic         ready;
    logic         exp_valid;
    int           exp_level;
    logic [W-1:0] exp_data;
  } vec_t;

  localparam logic [W-1:0] VA  = 64'h0807060504030201;
  localparam logic [W-1:0] VB  = 64'h100F0E0D0C0B0A09;
  localparam logic [W-1:0] VP  = 64'hA5C3A5C3A5C3A5C3;
  localparam logic [W-1:0] VAC = 64'hACACACACACACACAC;

  vec_t tbl[10];
  logic [W-1:0] dwords[20];
  int exp_cnt;

  initial begin
    tbl[0] = '{1'b1, 2'd0, VA, 1'b1, 1'b0, 0, '0};
    tbl[1] = '{1'b1, 2'd0, VB, 1'b1, 1'b0, 0, '0};
    tbl[2] = '{1'b0, 2'd0, '0, 1'b1, 1'b1, 1, VA};
    tbl[3] = '{1'b0, 2'd0, '0, 1'b1, 1'b1, 1, VB};
    tbl[4] = '{1'b0, 2'd0, '0, 1'b1, 1'b0, 0, '0};
    tbl[5] = '{1'b1, 2'd1, VP, 1'b0, 1'b0, 0, '0};
    tbl[6] = '{1'b1, 2'd1, VP, 1'b0, 1'b0, 0, '0};
    tbl[7] = '{1'b0, 2'd1, '0, 1'b0, 1'b0, 0, '0};
    tbl[8] = '{1'b0, 2'd1, '0, 1'b0, 1'b1, 1, VAC};
    tbl[9] = '{1'b0, 2'd1, '0, 1'b1, 1'b0, 0, '0};
`ifdef ADC_PACK_OVF_COUNT_EN
    exp_cnt = 1;
`else
    exp_cnt = 0;
`endif

    reset = 1; en = 0; mode = 0; in_data = '0; out_ready = 0; ovf_clr = 0;
    step();
    step();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_ovf_count", ovf_count, 16'd0);
    reset = 0;
    step();

    // Directed table: mode 0 latency/streaming, then mode 1 packing.
    for (int i = 0; i < 10; i++) begin
      en = tbl[i].en; mode = tbl[i].mode; in_data = tbl[i].data; out_ready = tbl[i].ready;
      step();
      chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].exp_valid);
      chk($sformatf("tbl%0d_level", i), level, tbl[i].exp_level);
      if (tbl[i].exp_valid) chk($sformatf("tbl%0d_data", i), out_data, tbl[i].exp_data);
    end

    // 1-bit mode: an interrupted word is discarded, a full run of 8 builds one word.
    out_ready = 0; mode = 2'd3; in_data = 64'h8000800080008000;
    en = 1; repeat (5) step();
    en = 0; step();
    en = 1; repeat (8) step();
    en = 0; repeat (3) step();
    chk("m3_level", level, 1);
    chk("m3_data", out_data, 64'hAAAAAAAAAAAAAAAA);
    out_ready = 1; step();
    chk("m3_drained", level, 0);

    // Overflow: 20 words into a 16-deep FIFO with no consumer.
    out_ready = 0; mode = 2'd0; en = 1;
    for (int i = 0; i < 20; i++) begin
      dwords[i] = {32'(i), 32'hC0DE0000 + 32'(i)};
      in_data = dwords[i];
      step();
    end
    en = 0; repeat (3) step();
    chk("ovf_level", level, DEPTH);
    chk("ovf_flag", overflow, 1'b1);
`ifdef ADC_PACK_OVF_COUNT_EN
    chk("ovf_count4", ovf_count, 16'd4);
`else
    chk("ovf_count4", ovf_count, 16'd0);
`endif
    ovf_clr = 1; step(); ovf_clr = 0;
    chk("clr_flag", overflow, 1'b0);
    chk("clr_count", ovf_count, 16'd0);

    // Write meets pop on a full FIFO, with ovf_clr on the same edge.
    en = 1; in_data = 64'hDEADBEEF00000000; step();
    en = 0; step();
    chk("full_head", out_data, dwords[0]);
    out_ready = 1; ovf_clr = 1; step();
    out_ready = 0; ovf_clr = 0;
    chk("drop_level", level, DEPTH - 1);
    chk("drop_flag", overflow, 1'b1);
    chk("drop_count", ovf_count, 16'(exp_cnt));
    out_ready = 1;
    for (int i = 1; i < 16; i++) begin
      chk($sformatf("drain%0d", i), out_data, dwords[i]);
      step();
    end
    chk("drain_empty", out_valid, 1'b0);
    out_ready = 0; ovf_clr = 1; step(); ovf_clr = 0;

    // Reset mid-word with buffered data; the next word uses only post-reset chunks.
    mode = 2'd0; en = 1;
    repeat (7) begin in_data = {$urandom, $urandom}; step(); end
    mode = 2'd2; in_data = '0; repeat (2) step();
    chk("pre_rst_level", level, 7);
    reset = 1; step(); reset = 0;
    chk("midrst_level", level, 0);
    chk("midrst_valid", out_valid, 1'b0);
    in_data = 64'hC0C0C0C0C0C0C0C0; repeat (4) step();
    en = 0; repeat (3) step();
    chk("postrst_level", level, 1);
    chk("postrst_data", out_data, 64'hFFFFFFFFFFFFFFFF);

    // Randomized traffic with bursts of slow consumers.
    for (int i = 0; i < 3000; i++) begin
      en      = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 24) == 0) mode = 2'($urandom);
      in_data = {$urandom, $urandom};
      out_ready = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      ovf_clr = ($urandom_range(0, 40) == 0);
      reset   = ($urandom_range(0, 400) == 0);
      step();
    end
    reset = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
